// File: rtl/pipe_reg_skid.sv
// IF/ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Carries {pc, instr} from fetch to decode, with flush, start gating and NOP bubbles.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-low
//   start_i      0 holds the block empty (synchronous clear), 1 runs
//   flush_i      synchronous flush, discards all stored entries
//   in_valid_i   fetch presents {pc_i, instr_i}
//   in_ready_o   block can accept this cycle
//   pc_i         fetched pc
//   instr_i      fetched instruction
//   out_valid_o  {pc_o, instr_o} valid to decode
//   out_ready_i  decode consumes this cycle
//   pc_o         pc to decode (0 when not valid)
//   instr_o      instruction to decode (NOP_INSTR when not valid)
//   count_o      occupancy 0..2
module pipe_reg_skid #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR =
    INSTR_W'(32'h00000013)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [1:0]         count_o
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

  logic acc;
  logic deq;

  // Ready depends only on state and start; reset level
  // keeps it low while the block is held in reset.
  assign in_ready_o  = rst_i & start_i & (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign count_o     = state_q;

  // Bubble values whenever nothing valid is presented.
  assign pc_o    = out_valid_o ? main_pc_q : '0;
  assign instr_o = out_valid_o ? main_instr_q : NOP_INSTR;

  assign acc = in_valid_i & in_ready_o;
  assign deq = out_valid_o & out_ready_i;

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (!start_i || flush_i) begin
      // Any same-cycle acc/deq is dropped.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d      = ONE;
            main_pc_d    = pc_i;
            main_instr_d = instr_i;
          end
        end
        ONE: begin
          if (acc && deq) begin
            main_pc_d    = pc_i;
            main_instr_d = instr_i;
          end else if (acc) begin
            state_d      = TWO;
            skid_pc_d    = pc_i;
            skid_instr_d = instr_i;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // Skid refills main so order is preserved.
          if (deq) begin
            state_d      = ONE;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid.
// Directed vector table, reset corner case and random scoreboard.
module tb_pipe_reg_skid;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [1:0]  count_o;

  int checks;
  int failures;

  pipe_reg_skid dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .pc_i        (pc_i),
    .instr_i     (instr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .pc_o        (pc_o),
    .instr_o     (instr_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic [1:0]  cnt;
    logic        ov;
    logic [31:0] epc;
    logic [31:0] eins;
    logic        irdy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp_v);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [1:0] cnt,
                         input logic ov,
                         input logic [31:0] epc,
                         input logic [31:0] eins,
                         input logic irdy);
    chk({tag, ".count"}, 32'(count_o), 32'(cnt));
    chk({tag, ".valid"}, 32'(out_valid_o), 32'(ov));
    chk({tag, ".pc"}, pc_o, epc);
    chk({tag, ".instr"}, instr_o, eins);
    chk({tag, ".in_ready"}, 32'(in_ready_o), 32'(irdy));
  endtask

  // Expected outputs after the edge; bubble when ov=0.
  function automatic vec_t mk(input logic st, input logic fl,
                              input logic iv, input logic [31:0] pc,
                              input logic [31:0] ins,
                              input logic ordy, input logic [1:0] cnt,
                              input logic [31:0] epc,
                              input logic [31:0] eins,
                              input logic irdy);
    vec_t v;
    v.st = st; v.fl = fl; v.iv = iv; v.pc = pc; v.ins = ins;
    v.ordy = ordy; v.cnt = cnt; v.ov = (cnt != 2'd0);
    v.epc = v.ov ? epc : 32'h0;
    v.eins = v.ov ? eins : NOP;
    v.irdy = irdy;
    return v;
  endfunction

  task automatic drive(input logic st, input logic fl,
                       input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy);
    start_i = st; flush_i = fl; in_valid_i = iv;
    pc_i = pc; instr_i = ins; out_ready_i = ordy;
  endtask

  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];

  initial begin
    checks = 0;
    failures = 0;
    rst_i = 1'b0;
    drive(1, 0, 0, 32'h0, 32'h0, 1);

    // Stream with full throughput.
    vq.push_back(mk(1,0,1,32'h0, 32'hA0000001,1,1,32'h0, 32'hA0000001,1));
    vq.push_back(mk(1,0,1,32'h4, 32'hB0000002,1,1,32'h4, 32'hB0000002,1));
    vq.push_back(mk(1,0,1,32'h8, 32'hC0000003,1,1,32'h8, 32'hC0000003,1));
    vq.push_back(mk(1,0,0,32'h0, 32'h0,       1,0,32'h0, 32'h0,       1));
    // Backpressure fills the skid; blocked push is ignored.
    vq.push_back(mk(1,0,1,32'h10,32'hD0000004,0,1,32'h10,32'hD0000004,1));
    vq.push_back(mk(1,0,1,32'h14,32'hE0000005,0,2,32'h10,32'hD0000004,0));
    vq.push_back(mk(1,0,1,32'h18,32'hF0000006,0,2,32'h10,32'hD0000004,0));
    vq.push_back(mk(1,0,0,32'h0, 32'h0,       1,1,32'h14,32'hE0000005,1));
    vq.push_back(mk(1,0,0,32'h0, 32'h0,       1,0,32'h0, 32'h0,       1));
    // Flush from TWO with a pending input.
    vq.push_back(mk(1,0,1,32'h20,32'h11111111,0,1,32'h20,32'h11111111,1));
    vq.push_back(mk(1,0,1,32'h24,32'h22222222,0,2,32'h20,32'h11111111,0));
    vq.push_back(mk(1,1,1,32'h40,32'h44444444,0,0,32'h0, 32'h0,       1));
    vq.push_back(mk(1,0,0,32'h0, 32'h0,       0,0,32'h0, 32'h0,       1));
    // Start gating and restart.
    vq.push_back(mk(0,0,1,32'h50,32'h55555555,1,0,32'h0, 32'h0,       0));
    vq.push_back(mk(1,0,1,32'h54,32'h66666666,0,1,32'h54,32'h66666666,1));
    vq.push_back(mk(0,0,1,32'h58,32'h77777777,0,0,32'h0, 32'h0,       0));
    // Simultaneous acc and deq in ONE.
    vq.push_back(mk(1,0,1,32'h60,32'h88888888,0,1,32'h60,32'h88888888,1));
    vq.push_back(mk(1,0,1,32'h64,32'h99999999,1,1,32'h64,32'h99999999,1));
    vq.push_back(mk(1,0,0,32'h0, 32'h0,       1,0,32'h0, 32'h0,       1));
    // Flush from ONE with acc and deq both asserted.
    vq.push_back(mk(1,0,1,32'h70,32'hAAAA0000,0,1,32'h70,32'hAAAA0000,1));
    vq.push_back(mk(1,1,1,32'h74,32'hBBBB0000,1,0,32'h0, 32'h0,       1));
    vq.push_back(mk(1,0,0,32'h0, 32'h0,       1,0,32'h0, 32'h0,       1));

    // Reset values, with start_i=1 to show ready is held low.
    #2;
    chk_all("reset", 2'd0, 1'b0, 32'h0, NOP, 1'b0);
    #10;
    rst_i = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].fl, vq[i].iv, vq[i].pc,
            vq[i].ins, vq[i].ordy);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].cnt, vq[i].ov,
              vq[i].epc, vq[i].eins, vq[i].irdy);
    end

    // Async reset mid-run while full.
    drive(1, 0, 1, 32'h100, 32'h0000A001, 0);
    @(posedge clk); #1;
    drive(1, 0, 1, 32'h104, 32'h0000A002, 0);
    @(posedge clk); #1;
    chk("prerst.count", 32'(count_o), 32'd2);
    #2;
    rst_i = 1'b0;
    #1;
    chk_all("asyncrst", 2'd0, 1'b0, 32'h0, NOP, 1'b0);
    @(negedge clk);
    rst_i = 1'b1;
    drive(1, 0, 1, 32'h200, 32'h0000B001, 1);
    @(posedge clk); #1;
    chk_all("postrst", 2'd1, 1'b1, 32'h200, 32'h0000B001, 1'b1);
    drive(1, 0, 0, 32'h0, 32'h0, 1);
    @(posedge clk); #1;

    // Random valid/ready against a FIFO model.
    for (int c = 0; c < 400; c++) begin
      logic iv, ordy, m_acc, m_deq;
      logic [31:0] npc, nin;
      iv = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 3) != 0);
      npc = 32'h1000 + 32'(c * 4);
      nin = $urandom;
      drive(1, 0, iv, npc, nin, ordy);
      #1;
      chk("sb.count", 32'(count_o), 32'(mq_pc.size()));
      chk("sb.in_ready", 32'(in_ready_o),
          32'(mq_pc.size() != 2));
      chk("sb.valid", 32'(out_valid_o),
          32'(mq_pc.size() != 0));
      if (mq_pc.size() != 0) begin
        chk("sb.pc", pc_o, mq_pc[0]);
        chk("sb.instr", instr_o, mq_in[0]);
      end
      m_acc = iv && (mq_pc.size() != 2);
      m_deq = ordy && (mq_pc.size() != 0);
      @(posedge clk); #1;
      if (m_deq) begin
        void'(mq_pc.pop_front());
        void'(mq_in.pop_front());
      end
      if (m_acc) begin
        mq_pc.push_back(npc);
        mq_in.push_back(nin);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
